// File: rtl/wbk_regfile.sv
// Writeback stage and 32-entry integer register file with two forwarded read ports.
// Optional retire counter enabled by defining WBK_RETIRE_CNT_EN.
module wbk_regfile #(
  parameter int XLEN    = 32,
  parameter int NB_REGS = 32,
  parameter int ADR_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             exe_ff_write_v_i,
  input  logic [ADR_W-1:0] exe_ff_rd_adr_i,
  input  logic [XLEN-1:0]  exe_ff_res_data_i,
  input  logic             flush_v_q_i,
  input  logic             flush_v_dly1_q_i,
  input  logic             res_w_v_i,
  input  logic [ADR_W-1:0] instr_write_adr_i,
  input  logic [XLEN-1:0]  instr_wbk_data_i,
  input  logic [ADR_W-1:0] rs1_adr_i,
  input  logic             rs1_unsign_i,
  input  logic [ADR_W-1:0] rs2_adr_i,
  input  logic             rs2_unsign_i,
  output logic [XLEN:0]    rs1_data_qual_o,
  output logic [XLEN:0]    rs2_data_qual_o,
  output logic [63:0]      retire_cnt_o
);

  logic [XLEN-1:0] regs [NB_REGS];
  logic            exe_fwd_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB_REGS; i++) regs[i] <= '0;
    end else if (res_w_v_i && (instr_write_adr_i != '0)) begin
      regs[instr_write_adr_i] <= instr_wbk_data_i;
    end
  end

  // Results computed under either flush cycle must never reach decode.
  assign exe_fwd_v = exe_ff_write_v_i & ~flush_v_q_i & ~flush_v_dly1_q_i;

  function automatic logic [XLEN:0] read_port(
    input logic [ADR_W-1:0] adr,
    input logic             unsign,
    input logic [XLEN-1:0]  arr_data
  );
    logic [XLEN-1:0] data;
    if (adr == '0)
      data = '0;
    else if (exe_fwd_v && (exe_ff_rd_adr_i == adr))
      data = exe_ff_res_data_i;
    else if (res_w_v_i && (instr_write_adr_i == adr))
      data = instr_wbk_data_i;
    else
      data = arr_data;
    return {(~unsign & data[XLEN-1]), data};
  endfunction

  always_comb begin
    rs1_data_qual_o = read_port(rs1_adr_i, rs1_unsign_i, regs[rs1_adr_i]);
    rs2_data_qual_o = read_port(rs2_adr_i, rs2_unsign_i, regs[rs2_adr_i]);
  end

`ifdef WBK_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Counts every committed writeback, x0 included; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      retire_cnt_q <= '0;
    else if (res_w_v_i)
      retire_cnt_q <= retire_cnt_q + 64'd1;
  end

  assign retire_cnt_o = retire_cnt_q;
`else
  assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wbk_regfile.sv
// Directed testbench for wbk_regfile; each task drives one scenario and checks inline.
module tb_wbk_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exe_ff_write_v_i;
  logic [4:0]  exe_ff_rd_adr_i;
  logic [31:0] exe_ff_res_data_i;
  logic        flush_v_q_i;
  logic        flush_v_dly1_q_i;
  logic        res_w_v_i;
  logic [4:0]  instr_write_adr_i;
  logic [31:0] instr_wbk_data_i;
  logic [4:0]  rs1_adr_i;
  logic        rs1_unsign_i;
  logic [4:0]  rs2_adr_i;
  logic        rs2_unsign_i;
  logic [32:0] rs1_data_qual_o;
  logic [32:0] rs2_data_qual_o;
  logic [63:0] retire_cnt_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cnt = '0;

  wbk_regfile dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .exe_ff_write_v_i  (exe_ff_write_v_i),
    .exe_ff_rd_adr_i   (exe_ff_rd_adr_i),
    .exe_ff_res_data_i (exe_ff_res_data_i),
    .flush_v_q_i       (flush_v_q_i),
    .flush_v_dly1_q_i  (flush_v_dly1_q_i),
    .res_w_v_i         (res_w_v_i),
    .instr_write_adr_i (instr_write_adr_i),
    .instr_wbk_data_i  (instr_wbk_data_i),
    .rs1_adr_i         (rs1_adr_i),
    .rs1_unsign_i      (rs1_unsign_i),
    .rs2_adr_i         (rs2_adr_i),
    .rs2_unsign_i      (rs2_unsign_i),
    .rs1_data_qual_o   (rs1_data_qual_o),
    .rs2_data_qual_o   (rs2_data_qual_o),
    .retire_cnt_o      (retire_cnt_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change 1ns after the edge so they are stable at the next one.
  task automatic tick();
`ifdef WBK_RETIRE_CNT_EN
    if (res_w_v_i && reset_n) exp_cnt = exp_cnt + 64'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exe_ff_write_v_i  = 1'b0;
    exe_ff_rd_adr_i   = '0;
    exe_ff_res_data_i = '0;
    flush_v_q_i       = 1'b0;
    flush_v_dly1_q_i  = 1'b0;
    res_w_v_i         = 1'b0;
    instr_write_adr_i = '0;
    instr_wbk_data_i  = '0;
  endtask

  task automatic wbk_write(input logic [4:0] adr, input logic [31:0] data);
    res_w_v_i         = 1'b1;
    instr_write_adr_i = adr;
    instr_wbk_data_i  = data;
    tick();
    res_w_v_i         = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs1_adr_i = 5'd5; rs1_unsign_i = 1'b0;
    rs2_adr_i = 5'd9; rs2_unsign_i = 1'b1;
    reset_n = 1'b0;
    #12;
    checks++;
    if (rs1_data_qual_o !== 33'h0) begin
      errors++; $display("[TB] FAIL reset_rs1 got %h want %h", rs1_data_qual_o, 33'h0);
    end
    checks++;
    if (rs2_data_qual_o !== 33'h0) begin
      errors++; $display("[TB] FAIL reset_rs2 got %h want %h", rs2_data_qual_o, 33'h0);
    end
    checks++;
    if (retire_cnt_o !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_cnt got %h want %h", retire_cnt_o, 64'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sign_ext();
    wbk_write(5'd5, 32'h8000_0000);
    rs1_adr_i = 5'd5; rs1_unsign_i = 1'b0;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h1_8000_0000) begin
      errors++; $display("[TB] FAIL sext_signed got %h want %h", rs1_data_qual_o, 33'h1_8000_0000);
    end
    rs1_unsign_i = 1'b1;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h0_8000_0000) begin
      errors++; $display("[TB] FAIL sext_unsigned got %h want %h", rs1_data_qual_o, 33'h0_8000_0000);
    end
    checks++;
    if (retire_cnt_o !== exp_cnt) begin
      errors++; $display("[TB] FAIL cnt_after_x5 got %h want %h", retire_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_x0();
    rs1_adr_i = 5'd0; rs1_unsign_i = 1'b0;
    rs2_adr_i = 5'd0; rs2_unsign_i = 1'b0;
    res_w_v_i = 1'b1; instr_write_adr_i = 5'd0; instr_wbk_data_i = 32'hDEAD_BEEF;
    exe_ff_write_v_i = 1'b1; exe_ff_rd_adr_i = 5'd0; exe_ff_res_data_i = 32'hCAFE_F00D;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h0) begin
      errors++; $display("[TB] FAIL x0_bypass_rs1 got %h want %h", rs1_data_qual_o, 33'h0);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h0) begin
      errors++; $display("[TB] FAIL x0_array_rs1 got %h want %h", rs1_data_qual_o, 33'h0);
    end
    checks++;
    if (rs2_data_qual_o !== 33'h0) begin
      errors++; $display("[TB] FAIL x0_array_rs2 got %h want %h", rs2_data_qual_o, 33'h0);
    end
    checks++;
    if (retire_cnt_o !== exp_cnt) begin
      errors++; $display("[TB] FAIL cnt_after_x0 got %h want %h", retire_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_fwd_priority();
    wbk_write(5'd7, 32'h33);
    rs2_adr_i = 5'd7; rs2_unsign_i = 1'b0;
    #1;
    checks++;
    if (rs2_data_qual_o !== 33'h33) begin
      errors++; $display("[TB] FAIL prio_array got %h want %h", rs2_data_qual_o, 33'h33);
    end
    exe_ff_write_v_i = 1'b1; exe_ff_rd_adr_i = 5'd7; exe_ff_res_data_i = 32'h11;
    res_w_v_i = 1'b1; instr_write_adr_i = 5'd7; instr_wbk_data_i = 32'h22;
    #1;
    checks++;
    if (rs2_data_qual_o !== 33'h11) begin
      errors++; $display("[TB] FAIL prio_exe_wins got %h want %h", rs2_data_qual_o, 33'h11);
    end
    exe_ff_write_v_i = 1'b0;
    #1;
    checks++;
    if (rs2_data_qual_o !== 33'h22) begin
      errors++; $display("[TB] FAIL prio_wbk_bypass got %h want %h", rs2_data_qual_o, 33'h22);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs2_data_qual_o !== 33'h22) begin
      errors++; $display("[TB] FAIL prio_array_updated got %h want %h", rs2_data_qual_o, 33'h22);
    end
  endtask

  task automatic test_flush();
    wbk_write(5'd3, 32'h55);
    rs1_adr_i = 5'd3; rs1_unsign_i = 1'b0;
    exe_ff_write_v_i = 1'b1; exe_ff_rd_adr_i = 5'd3; exe_ff_res_data_i = 32'h44;
    flush_v_q_i = 1'b1;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h55) begin
      errors++; $display("[TB] FAIL flush_q got %h want %h", rs1_data_qual_o, 33'h55);
    end
    flush_v_q_i = 1'b0; flush_v_dly1_q_i = 1'b1;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h55) begin
      errors++; $display("[TB] FAIL flush_dly1 got %h want %h", rs1_data_qual_o, 33'h55);
    end
    flush_v_dly1_q_i = 1'b0;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h44) begin
      errors++; $display("[TB] FAIL flush_none got %h want %h", rs1_data_qual_o, 33'h44);
    end
    exe_ff_rd_adr_i = 5'd4;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h55) begin
      errors++; $display("[TB] FAIL exe_adr_miss got %h want %h", rs1_data_qual_o, 33'h55);
    end
    idle_inputs();
  endtask

  task automatic test_same_addr();
    rs1_adr_i = 5'd9; rs1_unsign_i = 1'b0;
    rs2_adr_i = 5'd9; rs2_unsign_i = 1'b1;
    res_w_v_i = 1'b1; instr_write_adr_i = 5'd9; instr_wbk_data_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h1_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL same_rs1 got %h want %h", rs1_data_qual_o, 33'h1_FFFF_FFFF);
    end
    checks++;
    if (rs2_data_qual_o !== 33'h0_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL same_rs2 got %h want %h", rs2_data_qual_o, 33'h0_FFFF_FFFF);
    end
    tick();
    idle_inputs();
    rs2_unsign_i = 1'b0;
    #1;
    checks++;
    if (rs2_data_qual_o !== 33'h1_FFFF_FFFF) begin
      errors++; $display("[TB] FAIL same_array_rs2 got %h want %h", rs2_data_qual_o, 33'h1_FFFF_FFFF);
    end
    checks++;
    if (retire_cnt_o !== exp_cnt) begin
      errors++; $display("[TB] FAIL cnt_after_x9 got %h want %h", retire_cnt_o, exp_cnt);
    end
  endtask

`ifdef WBK_RETIRE_CNT_EN
  task automatic test_cnt_wrap();
    force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    res_w_v_i = 1'b1; instr_write_adr_i = 5'd0; instr_wbk_data_i = 32'h0;
    tick();
    res_w_v_i = 1'b0;
    #1;
    checks++;
    if (retire_cnt_o !== 64'h0) begin
      errors++; $display("[TB] FAIL cnt_wrap got %h want %h", retire_cnt_o, 64'h0);
    end
  endtask
`endif

  task automatic test_async_reset();
    res_w_v_i = 1'b1; instr_write_adr_i = 5'd12; instr_wbk_data_i = 32'h1234_5678;
    tick();
    instr_write_adr_i = 5'd13; instr_wbk_data_i = 32'h0BAD_F00D;
    tick();
    #2;
    reset_n = 1'b0;
    res_w_v_i = 1'b0;
    exp_cnt = '0;
    rs1_adr_i = 5'd12; rs1_unsign_i = 1'b1;
    rs2_adr_i = 5'd9;  rs2_unsign_i = 1'b0;
    #1;
    checks++;
    if (rs1_data_qual_o !== 33'h0) begin
      errors++; $display("[TB] FAIL async_rst_x12 got %h want %h", rs1_data_qual_o, 33'h0);
    end
    checks++;
    if (rs2_data_qual_o !== 33'h0) begin
      errors++; $display("[TB] FAIL async_rst_x9 got %h want %h", rs2_data_qual_o, 33'h0);
    end
    checks++;
    if (retire_cnt_o !== 64'h0) begin
      errors++; $display("[TB] FAIL async_rst_cnt got %h want %h", retire_cnt_o, 64'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sign_ext();
    test_x0();
    test_fwd_priority();
    test_flush();
    test_same_addr();
`ifdef WBK_RETIRE_CNT_EN
    test_cnt_wrap();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
